booth_divider: RTL and testbench
================================

Name: booth_divider

Overview:
- Sequential signed integer divider that is the inverse companion of the team's sequential Booth multiplier.
- Accepts a signed dividend and divisor and produces quotient and remainder, one quotient bit per clock (restoring on magnitudes, then sign correction).
- Sits beside the multiplier in the arithmetic datapath. Uses a start/busy/done handshake so a controller FSM can sequence multiply and divide operations.

Parameters:
- WIDTH, 8, operand/result width in bits (two's complement); minimum 2.
- CNT_W, 4, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend; captured on the accepting edge.
- divisor  input  WIDTH  signed divisor; captured on the accepting edge.
- quotient  output  WIDTH  signed quotient, registered.
- remainder  output  WIDTH  signed remainder, registered.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse; results valid from this cycle onward.
- div_by_zero  output  1  sticky-until-next-done flag: divisor was 0.
- overflow  output  1  flag: result not representable (most negative value / -1).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - quotient, remainder, busy, done, div_by_zero and overflow all 0.
  - Internal counter and registers cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, ITER, FIX.
- IDLE:
  - busy=0.
  - On a clk edge with start=1, latch the operand signs, |dividend| and |divisor|, and clear the partial remainder and count. Compute magnitudes in WIDTH+1 bits so the most negative value is exact.
  - If divisor==0, go to FIX with dz set. Otherwise go to ITER.
  - start=0 keeps the block in IDLE.
- ITER (busy=1):
  - Each edge shifts {partial remainder, dividend magnitude} left by 1.
  - Trial subtract: partial remainder minus divisor magnitude, computed in WIDTH+1 bits.
  - If the difference is non-negative, keep it and shift in quotient bit 1. Otherwise restore and shift in 0.
  - count increments. After WIDTH iterations (count==WIDTH-1 on that edge), go to FIX.
- FIX (busy=1), on the next edge:
  - Register the outputs, pulse done=1 for exactly one cycle, and return to IDLE.
  - Quotient is negated if the operand signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend. Invariant: dividend = quotient*divisor + remainder.
  - Divide-by-zero: quotient = all ones, remainder = dividend, div_by_zero=1, overflow=0.
  - Overflow (dividend = -2^(WIDTH-1), divisor = -1): quotient = -2^(WIDTH-1) (wrapped), remainder=0, overflow=1.
  - Otherwise both flags are 0. Flags update only with done.
- Latency:
  - Normal operation: done is high in the cycle following the (WIDTH+1)th edge after the accepting edge (WIDTH=8: 10 edges including the accepting edge).
  - Divide-by-zero: done follows the 2nd edge.
- Handshake rules:
  - start is ignored while busy=1; operand changes during busy have no effect.
  - done and busy are never high together except in the done cycle (busy=0 in the done cycle since state=IDLE).
  - start high during the done cycle is accepted on that edge (back-to-back operation, no bubble).
- Outputs hold their last value until the next done or reset.

Test Plan:
- 100 / 7 -> quotient=0x0E, remainder=0x02, flags 0; done exactly 10 edges after the start edge, with busy high for 9 cycles.
- -100 / 7 -> quotient=0xF2 (-14), remainder=0xFE (-2); 100 / -7 -> quotient=0xF2, remainder=0x02; -100 / -7 -> quotient=0x0E, remainder=0xFE.
- -128 / -1 -> quotient=0x80, remainder=0x00, overflow=1; -128 / 1 -> quotient=0x80, remainder=0, overflow=0.
- 5 / 0 -> quotient=0xFF, remainder=0x05, div_by_zero=1, done after 2 edges; the next valid divide clears the flag.
- start pulsed again mid-operation with different operands -> ignored, first result unchanged; start held during the done cycle -> second op accepted, its done follows 10 edges later.
- reset driven low at iteration 4 -> all outputs 0 immediately (asynchronous), no done; after release, 127 / 127 -> quotient=0x01, remainder=0x00.

Source files
------------

// File: rtl/booth_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient bit
// per clock, followed by a sign-correction cycle. Uses a start/busy/done handshake.
module booth_divider #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quotient_d, remainder_d;
    logic             done_d, dbz_d, ovf_d;

    logic [WIDTH:0]   dvd_ext, dsr_ext, dvd_mag, dsr_mag, shifted, diff;
    logic [WIDTH-1:0] q_signed, r_signed, dvd_orig;

    // Magnitudes carry an extra bit so the most negative operand is exact.
    assign dvd_ext = {dividend[WIDTH-1], dividend};
    assign dsr_ext = {divisor[WIDTH-1], divisor};
    assign dvd_mag = dividend[WIDTH-1] ? -dvd_ext : dvd_ext;
    assign dsr_mag = divisor[WIDTH-1] ? -dsr_ext : dsr_ext;

    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign diff    = shifted - dsr_q;

    assign q_signed = neg_q ? -quo_q : quo_q;
    assign r_signed = dvd_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    // On divide-by-zero quo_q still holds |dividend|; rebuild the original operand.
    assign dvd_orig = dvd_neg_q ? -quo_q : quo_q;

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        dvd_neg_d   = dvd_neg_q;
        dz_d        = dz_q;
        quotient_d  = quotient;
        remainder_d = remainder;
        done_d      = 1'b0;
        dbz_d       = div_by_zero;
        ovf_d       = overflow;
        case (state_q)
            IDLE: begin
                if (start) begin
                    neg_d     = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    dvd_neg_d = dividend[WIDTH-1];
                    quo_d     = dvd_mag[WIDTH-1:0];
                    dsr_d     = dsr_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    dz_d      = (divisor == '0);
                    state_d   = (divisor == '0) ? FIX : ITER;
                end
            end
            ITER: begin
                if (diff[WIDTH]) begin
                    rem_d = shifted;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = diff;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_orig;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                end else begin
                    quotient_d  = q_signed;
                    remainder_d = r_signed;
                    dbz_d       = 1'b0;
                    // Only -2^(W-1) / -1 yields a positive quotient with the MSB set.
                    ovf_d       = ~neg_q & quo_q[WIDTH-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            dsr_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            dvd_neg_q   <= 1'b0;
            dz_q        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            dvd_neg_q   <= dvd_neg_d;
            dz_q        <= dz_d;
            quotient    <= quotient_d;
            remainder   <= remainder_d;
            done        <= done_d;
            div_by_zero <= dbz_d;
            overflow    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: directed vector table, handshake/reset sequences,
// and randomized operands against an integer-arithmetic reference model.
module tb_booth_divider;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'd0;
    logic [7:0] divisor = 8'd0;
    logic [7:0] quotient, remainder;
    logic       busy, done, div_by_zero, overflow;

    int total = 0;
    int bad = 0;

    booth_divider #(.WIDTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Signed integer reference: SV / and % truncate toward zero, remainder follows dividend.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
        int ia;
        int ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (ib == 0) begin
            q  = 8'hFF;
            r  = a;
            dz = 1'b1;
        end else if (ia == -128 && ib == -1) begin
            q  = 8'h80;
            r  = 8'h00;
            ov = 1'b1;
        end else begin
            q = 8'(ia / ib);
            r = 8'(ia % ib);
        end
    endfunction

    task automatic accept_now(input logic [7:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        accept_now(a, b);
    endtask

    // Counts edges from the accepting edge (inclusive) until done is seen.
    task automatic wait_done(input int poke_at, output int edges, output int busyc);
        edges = 1;
        busyc = busy ? 1 : 0;
        while (!done && edges < 40) begin
            if (edges == poke_at) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
            if (busy) busyc++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: no done after %0d edges", edges);
        end
    endtask

    task automatic check_op(input string tag, input vec_t v);
        int e;
        int bc;
        launch(v.a, v.b);
        wait_done(0, e, bc);
        chk({tag, ".quotient"}, quotient, v.q);
        chk({tag, ".remainder"}, remainder, v.r);
        chk({tag, ".div_by_zero"}, div_by_zero, v.dz);
        chk({tag, ".overflow"}, overflow, v.ov);
        chk({tag, ".latency"}, e, v.dz ? 2 : 10);
        chk({tag, ".busy_in_done"}, busy, 0);
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".hold"}, quotient, v.q);
    endtask

    initial begin
        int   e;
        int   bc;
        bit   seen;
        vec_t v;

        vecs[0]  = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0};
        vecs[1]  = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0};
        vecs[2]  = '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0};
        vecs[3]  = '{8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0};
        vecs[4]  = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1};
        vecs[5]  = '{8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{8'd5,   8'd0,   8'hFF, 8'h05, 1'b1, 1'b0};
        vecs[7]  = '{8'd127, 8'd127, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{8'h80,  8'd0,   8'hFF, 8'h80, 1'b1, 1'b0};
        vecs[9]  = '{8'd0,   8'd5,   8'h00, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{8'd7,   8'd100, 8'h00, 8'h07, 1'b0, 1'b0};
        vecs[11] = '{8'hFF,  8'd2,   8'h00, 8'hFF, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset.quotient", quotient, 0);
        chk("reset.remainder", remainder, 0);
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.flags", {div_by_zero, overflow}, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Busy duration for the reference case.
        launch(8'd100, 8'd7);
        wait_done(0, e, bc);
        chk("busy_cycles", bc, 9);

        // start pulsed mid-operation with other operands is ignored.
        launch(8'd100, 8'd7);
        wait_done(3, e, bc);
        chk("midstart.quotient", quotient, 8'h0E);
        chk("midstart.remainder", remainder, 8'h02);
        chk("midstart.latency", e, 10);

        // start held in the done cycle is accepted with no bubble.
        launch(8'd100, 8'd7);
        wait_done(0, e, bc);
        chk("b2b.first", quotient, 8'h0E);
        accept_now(8'h9C, 8'd7);
        wait_done(0, e, bc);
        chk("b2b.latency", e, 10);
        chk("b2b.quotient", quotient, 8'hF2);
        chk("b2b.remainder", remainder, 8'hFE);

        for (int i = 0; i < 150; i++) begin
            v.a = 8'($urandom);
            v.b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) v.b = 8'd0;
            if ($urandom_range(0, 9) == 0) begin
                v.a = 8'h80;
                v.b = 8'hFF;
            end
            model(v.a, v.b, v.q, v.r, v.dz, v.ov);
            check_op($sformatf("rnd%0d_%0h_%0h", i, v.a, v.b), v);
        end

        // Asynchronous reset in the middle of an operation.
        check_op("pre_reset", vecs[2]);
        launch(8'd100, 8'd7);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort.quotient", quotient, 0);
        chk("abort.remainder", remainder, 0);
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.flags", {div_by_zero, overflow}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("abort.no_done", seen, 0);
        check_op("post_reset", vecs[7]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
